// File: rtl/vga_pkg.sv
// vga_pkg: framebuffer geometry, fill FSM states and pixel packing shared by the fill engine.
package vga_pkg;
   localparam int ROW_WORDS = 80;
   localparam int FB_WORDS  = 4016;
   localparam int AW        = 15;

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   // Even pixel lives in bits 7:0, odd pixel in bits 15:8.
   function automatic logic [15:0] pack_pixels(input logic [7:0] even, input logic [7:0] odd);
      return {odd, even};
   endfunction

   function automatic logic fill_empty(input logic [6:0] x0, input logic [6:0] y0,
                                       input logic [6:0] w, input logic [6:0] h);
      logic [AW-1:0] first;
      first = (AW'(y0) << 6) + (AW'(y0) << 4) + AW'(x0);
      return w == 7'd0 || h == 7'd0 || x0 >= 7'(ROW_WORDS) || first >= AW'(FB_WORDS);
   endfunction
endpackage

// File: rtl/vga_rect_addr.sv
// vga_rect_addr: incremental row-major word address walker for a rectangle, clipped to the
// row edge and to the end of the framebuffer.
module vga_rect_addr import vga_pkg::*; (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          advance,
   input  logic [6:0]    x0,
   input  logic [6:0]    y0,
   input  logic [6:0]    w,
   input  logic [6:0]    h,
   output logic [AW-1:0] addr,
   output logic          last,
   output logic          valid
);
   logic [AW-1:0] row_base;
   logic [6:0]    xs, ws, hs, col, rows;
   logic [6:0]    room;
   logic          row_end;

   assign room = 7'(ROW_WORDS) - x0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         row_base <= '0;
         xs       <= '0;
         ws       <= '0;
         hs       <= '0;
         col      <= '0;
         rows     <= '0;
      end else if (load) begin
         row_base <= (AW'(y0) << 6) + (AW'(y0) << 4);
         xs       <= x0;
         ws       <= (w < room) ? w : room;
         hs       <= h;
         col      <= '0;
         rows     <= '0;
      end else if (advance) begin
         col      <= row_end ? 7'd0 : col + 7'd1;
         row_base <= row_end ? row_base + AW'(ROW_WORDS) : row_base;
         rows     <= row_end ? rows + 7'd1 : rows;
      end

   assign row_end = col == ws - 7'd1;
   assign addr    = row_base + AW'(xs) + AW'(col);
   assign valid   = addr < AW'(FB_WORDS);
   // Row-major order means the word at FB_WORDS-1 is always the final one written.
   assign last    = valid && (addr == AW'(FB_WORDS - 1) || (row_end &&
                    (rows == hs - 7'd1 || row_base + AW'(ROW_WORDS) + AW'(xs) >= AW'(FB_WORDS))));
endmodule

// File: rtl/vga_fill.sv
// vga_fill: rectangle-fill engine owning the framebuffer write port; CPU direct writes
// take priority and stall the fill.
module vga_fill import vga_pkg::*; (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_we,
   input  logic [15:0]   cpu_data,
   input  logic          start,
   input  logic [6:0]    x0,
   input  logic [6:0]    y0,
   input  logic [6:0]    w,
   input  logic [6:0]    h,
   input  logic [15:0]   color,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] fb_addr,
   output logic          fb_we,
   output logic [15:0]   fb_data
);
   state_t        state, next;
   logic          load, adv, last, valid;
   logic [AW-1:0] ra_addr;
   logic [15:0]   color_q;

   vga_rect_addr u_addr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .advance (adv),
      .x0      (x0),
      .y0      (y0),
      .w       (w),
      .h       (h),
      .addr    (ra_addr),
      .last    (last),
      .valid   (valid)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= next;

   always_comb begin
      next = state;
      load = 1'b0;
      adv  = 1'b0;
      case (state)
         IDLE: if (start) begin
            load = 1'b1;
            next = fill_empty(x0, y0, w, h) ? DONE : FILL;
         end
         FILL: if (abort) next = DONE;
         else if (!cpu_we) begin
            adv  = valid;
            next = (last || !valid) ? DONE : FILL;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         color_q <= '0;
         fb_we   <= 1'b0;
         fb_addr <= '0;
         fb_data <= '0;
      end else begin
         color_q <= load ? color : color_q;
         fb_we   <= cpu_we || adv;
         fb_addr <= cpu_we ? cpu_addr : adv ? ra_addr : fb_addr;
         fb_data <= cpu_we ? cpu_data : adv ? color_q : fb_data;
      end

   assign busy = state == FILL;
   assign done = state == DONE;
endmodule

// File: tb/tb_vga_fill.sv
// tb_vga_fill: randomized and directed checks of vga_fill against a nested-loop rectangle model.
module tb_vga_fill;
   import vga_pkg::*;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic          cpu_we = 1'b0;
   logic [15:0]   cpu_data = '0;
   logic          start = 1'b0, abort = 1'b0;
   logic [6:0]    x0 = '0, y0 = '0, w = '0, h = '0;
   logic [15:0]   color = '0;
   logic          busy, done, fb_we;
   logic [AW-1:0] fb_addr;
   logic [15:0]   fb_data;
   int            total = 0, bad = 0;
   int            exp_q[$];

   always #5 clk = ~clk;

   vga_fill dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cpu_addr (cpu_addr),
      .cpu_we   (cpu_we),
      .cpu_data (cpu_data),
      .start    (start),
      .x0       (x0),
      .y0       (y0),
      .w        (w),
      .h        (h),
      .color    (color),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .fb_addr  (fb_addr),
      .fb_we    (fb_we),
      .fb_data  (fb_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Every word of the clipped rectangle in raster order; the fill stops at the first word past the buffer.
   function automatic void model(input int x, input int y, input int ww, input int hh);
      int wc, a;
      exp_q.delete();
      if (ww == 0 || hh == 0 || x >= ROW_WORDS) return;
      wc = (ww < ROW_WORDS - x) ? ww : ROW_WORDS - x;
      for (int r = 0; r < hh; r++)
         for (int c = 0; c < wc; c++) begin
            a = (y + r) * ROW_WORDS + x + c;
            if (a >= FB_WORDS) return;
            exp_q.push_back(a);
         end
   endfunction

   task automatic run_fill(input int x, input int y, input int ww, input int hh, input logic [15:0] col,
                           input int stall_at, input int stall_len, input int abort_after, input bit ab_start);
      int n, seen = 0, stalls = 0, stall_left = 0, k;
      bit cpu_pend = 0, fin = 0, ab_sent = 0, stall_used = 0;
      logic [AW-1:0] ca = '0;
      logic [15:0]   cd = '0;
      model(x, y, ww, hh);
      n = (abort_after >= 0 && abort_after < exp_q.size()) ? abort_after : exp_q.size();
      @(negedge clk);
      x0 = 7'(x); y0 = 7'(y); w = 7'(ww); h = 7'(hh); color = col; start = 1'b1; abort = ab_start;
      @(posedge clk); #1;
      for (k = 0; k < 2000 && !fin; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (cpu_pend) begin
            chk("cpu_we", fb_we, 1);
            chk("cpu_addr", fb_addr, ca);
            chk("cpu_data", fb_data, cd);
         end else if (fb_we) begin
            if (seen < n) begin
               chk("fill_addr", fb_addr, exp_q[seen]);
               chk("fill_data", fb_data, col);
            end else chk("fill_count", seen + 1, n);
            seen++;
         end
         if (done) begin
            fin = 1;
            chk("done_words", seen, n);
            chk("done_cycle", k, n + stalls + int'(ab_sent));
            chk("done_busy", busy, 0);
            if (n > 0 && !ab_sent) chk("last_with_done", fb_we && !cpu_pend, 1);
         end else chk("busy", busy, 1);
         cpu_pend = 0;
         if (!fin) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            x0 = 7'($urandom); y0 = 7'($urandom); w = 7'($urandom); h = 7'($urandom);
            abort = 1'b0; cpu_we = 1'b0;
            if (abort_after >= 0 && seen == abort_after && !ab_sent) begin
               abort = 1'b1;
               ab_sent = 1;
            end else begin
               if (!stall_used && stall_len > 0 && seen == stall_at) begin
                  stall_left = stall_len;
                  stall_used = 1;
               end
               if (stall_left > 0) begin
                  ca = AW'($urandom); cd = 16'($urandom);
                  cpu_addr = ca; cpu_data = cd; cpu_we = 1'b1;
                  stall_left--; stalls++; cpu_pend = 1;
               end
            end
         end
      end
      if (!fin) chk("timeout", fin, 1);
      @(negedge clk);
      start = 1'b0; abort = 1'b0; cpu_we = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fb_we", fb_we, 0);
      chk("rst_fb_addr", fb_addr, 0);
      chk("rst_fb_data", fb_data, 0);
      @(negedge clk) rst_n = 1'b1;

      @(negedge clk);
      cpu_we = 1'b1; cpu_addr = AW'(100); cpu_data = 16'hBEEF;
      @(posedge clk); #1;
      chk("cpuw_we", fb_we, 1);
      chk("cpuw_addr", fb_addr, 100);
      chk("cpuw_data", fb_data, 16'hBEEF);
      chk("cpuw_busy", busy, 0);
      @(negedge clk) cpu_we = 1'b0;
      @(posedge clk); #1;
      chk("cpuw_idle_we", fb_we, 0);

      @(negedge clk) abort = 1'b1;
      @(posedge clk); #1;
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_done", done, 0);
      @(negedge clk) abort = 1'b0;

      run_fill(2, 1, 3, 2, 16'h1234, -1, 0, -1, 0);
      run_fill(78, 0, 5, 2, 16'hA55A, -1, 0, -1, 0);
      run_fill(0, 50, 80, 4, 16'h0F0F, -1, 0, -1, 0);
      run_fill(0, 51, 80, 4, 16'h7777, -1, 0, -1, 0);
      run_fill(2, 1, 3, 2, 16'h1234, 2, 2, -1, 0);
      run_fill(2, 1, 3, 2, 16'h4321, -1, 0, 3, 0);
      run_fill(5, 3, 4, 3, 16'hC0DE, -1, 0, -1, 1);
      run_fill(85, 2, 4, 3, 16'h1111, -1, 0, -1, 0);

      @(negedge clk);
      x0 = 7'd0; y0 = 7'd0; w = 7'd20; h = 7'd3; start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("amid_busy", busy, 0);
      chk("amid_fb_we", fb_we, 0);
      chk("amid_fb_addr", fb_addr, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("amid_no_done", done, 0);
         chk("amid_no_we", fb_we, 0);
      end
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 40; i++)
         run_fill($urandom_range(0, 85), ($urandom_range(0, 1) == 1) ? $urandom_range(45, 55) : $urandom_range(0, 50),
                  $urandom_range(0, 12), $urandom_range(0, 5), 16'($urandom),
                  $urandom_range(0, 8), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1, $urandom_range(0, 1) == 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
